ext2red_lane_buffer: RTL and testbench
======================================

# ext2red_lane_buffer

Parametrised extend-to-reduce buffer: NUM_EXTEND independent per-lane FIFOs, each DEPTH entries of FIFO_WIDTH-bit offsets, written by the extend lanes and drained in lock-step by the reduce unit. It sits between the extend array and the reduce unit and presents the ext2red-style offset/valid/read view to reduce. Unlike a bare offset/valid bundle, it adds per-lane buffering with full/almost-full backpressure, an all-lanes-ready qualifier, a synchronous flush between tiles, and optional error flags.

## Interface
- FIFO_WIDTH, 30, bits per offset entry
- NUM_EXTEND, 8, number of extend lanes
- DEPTH, 8, entries per lane; power of two, at least 2
- AFULL_THRESH, DEPTH-2, occupancy at or above which lane_afull asserts; range 1..DEPTH-1
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- lane_wen  input  NUM_EXTEND  per-lane write strobe
- lane_din  input  FIFO_WIDTH*NUM_EXTEND  per-lane write data; lane i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- lane_full  output  NUM_EXTEND  lane occupancy == DEPTH
- lane_afull  output  NUM_EXTEND  lane occupancy >= AFULL_THRESH
- offset  output  FIFO_WIDTH*NUM_EXTEND  head entry of each lane, same packing as lane_din; 0 for an empty lane
- valid  output  NUM_EXTEND  lane non-empty
- all_valid  output  1  &valid; reduce may fire only when this is high
- read  input  1  pop the head of every lane
- flush  input  1  synchronous clear of all lanes
- err_overflow  output  1  sticky; present only with EXT2RED_ERR_EN
- err_underflow  output  1  sticky; present only with EXT2RED_ERR_EN

## Operation
- Per-lane state:
  - flop storage array
  - write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH
  - occupancy counter, log2(DEPTH)+1 bits, range 0..DEPTH
- Write: lane_wen[i] with lane i not full stores lane_din slice i at wr_ptr[i]; wr_ptr[i] and count[i] increment.
- Read: read with all_valid high pops every lane; each rd_ptr increments and each count decrements. Read with all_valid low changes no state.
- Simultaneous write and pop on a lane:
  - Count is unchanged; both pointers advance.
  - This is legal even when the lane is full: the write is accepted because the pop frees the slot in the same cycle.
- Write to a full lane without an effective pop is dropped; storage and pointers are unchanged.
- Lanes are independent. Occupancies may differ, and all_valid waits for the slowest lane.
- offset slice i:
  - Combinational read of storage[rd_ptr[i]] (first-word fall-through), gated to 0 when count[i] == 0.
  - Writing an empty lane does not bypass storage: data appears the cycle after the write.
- flush:
  - Clears all pointers and counts on the next edge.
  - Has priority over lane_wen and read in the same cycle; those writes are discarded.
  - Storage contents are not cleared; outputs read 0 because lanes are empty.
- Reset (rst_n low, asynchronous) forces:
  - pointers and counts to 0
  - valid, all_valid, lane_full, lane_afull, err_* to 0
  - offset to 0
- Reset is honoured mid-operation: in-flight data is lost and there is no partial pop.

## Timing
- Write-to-visible latency: write at edge t; valid/offset reflect it after edge t.
- Read-to-next-head: pop at edge t; next head is on offset after edge t.
- A steady stream at one write per lane per cycle with read every cycle sustains full throughput at occupancy 1.
- lane_full, lane_afull, valid and all_valid are registered-state derived: combinational from count only, never from the current cycle's inputs.
- read and lane_wen are sampled only at the rising clk edge; no combinational path from inputs to outputs other than through state.

## Configuration
- EXT2RED_ERR_EN defined:
  - err_overflow sets on any lane_wen[i] dropped because lane i is full.
  - err_underflow sets on read asserted while all_valid is low.
  - Both flags are sticky until rst_n or flush; flush clears them on the same edge it clears lanes.
- EXT2RED_ERR_EN undefined:
  - Both ports and their logic are absent.
  - Dropped writes and ignored reads are silent.

## Test plan
- Reset, then no stimulus -> all outputs 0; lane_full=0, all_valid=0.
- Write 0x1 to lane 0 only; then read pulse -> valid=8'h01, all_valid=0, offset lane 0 = 0x1, read ignored, err_underflow=1 (ERR_EN).
- Write lane i value i+0x100 to all 8 lanes in one cycle, then read -> next cycle all_valid=1 with offset lanes = 0x100..0x107; after read, valid=0 and offset=0.
- Fill lane 3 with DEPTH=8 writes 0..7 -> lane_afull[3]=1 after the 6th write and lane_full[3]=1 after the 8th. A 9th write is dropped and err_overflow=1. A 9th write coincident with a full-array pop is accepted and count stays 8.
- With 5 entries in every lane, pulse flush together with lane_wen=8'hFF -> all counts 0, valid=0, offset=0, err_* cleared.
- Assert rst_n low asynchronously mid-stream with lanes partially full -> outputs 0 immediately without a clock edge. After release, the first write of 0x2A to all lanes reads back 0x2A on every lane.

Source files
------------

// File: rtl/ext2red_lane_buffer.sv
// Extend-to-reduce buffer: one FIFO per extend lane, drained in lock-step by reduce.
// Optional sticky overflow/underflow flags are built when EXT2RED_ERR_EN is defined.
module ext2red_lane_buffer #(
    parameter int unsigned FIFO_WIDTH   = 30,
    parameter int unsigned NUM_EXTEND   = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_EXTEND-1:0]            lane_wen,
    input  logic [FIFO_WIDTH*NUM_EXTEND-1:0] lane_din,
    output logic [NUM_EXTEND-1:0]            lane_full,
    output logic [NUM_EXTEND-1:0]            lane_afull,
    output logic [FIFO_WIDTH*NUM_EXTEND-1:0] offset,
    output logic [NUM_EXTEND-1:0]            valid,
    output logic                             all_valid,
    input  logic                             read,
    input  logic                             flush
`ifdef EXT2RED_ERR_EN
    ,
    output logic                             err_overflow,
    output logic                             err_underflow
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

    logic [FIFO_WIDTH-1:0] mem    [NUM_EXTEND][DEPTH];
    logic [PTR_W-1:0]      wr_ptr [NUM_EXTEND];
    logic [PTR_W-1:0]      rd_ptr [NUM_EXTEND];
    logic [CNT_W-1:0]      count  [NUM_EXTEND];

    logic                  pop;
    logic [NUM_EXTEND-1:0] wr_ok;

    // Status flags come from count alone; only pop/wr_ok look at this cycle's inputs.
    always_comb begin
        lane_full  = '0;
        lane_afull = '0;
        valid      = '0;
        offset     = '0;
        for (int unsigned i = 0; i < NUM_EXTEND; i++) begin
            lane_full[i]  = (count[i] == FULL_CNT);
            lane_afull[i] = (count[i] >= AFULL_CNT);
            valid[i]      = (count[i] != '0);
            if (valid[i])
                offset[i*FIFO_WIDTH +: FIFO_WIDTH] = mem[i][rd_ptr[i]];
        end
        all_valid = &valid;
    end

    // A full lane still accepts a write when the same edge pops its head.
    always_comb begin
        pop   = read & all_valid;
        wr_ok = '0;
        for (int unsigned i = 0; i < NUM_EXTEND; i++)
            wr_ok[i] = lane_wen[i] & (~lane_full[i] | pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_EXTEND; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < NUM_EXTEND; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_EXTEND; i++) begin
                if (wr_ok[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop)
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (wr_ok[i] && !pop)
                    count[i] <= count[i] + 1'b1;
                else if (!wr_ok[i] && pop)
                    count[i] <= count[i] - 1'b1;
            end
        end
    end

    // Storage is never cleared; emptiness alone gates what reaches offset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_EXTEND; i++) begin
            if (!flush && wr_ok[i])
                mem[i][wr_ptr[i]] <= lane_din[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

`ifdef EXT2RED_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (flush) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (|(lane_wen & ~wr_ok))
                err_overflow <= 1'b1;
            if (read && !all_valid)
                err_underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ext2red_lane_buffer.sv
// Scoreboard bench for ext2red_lane_buffer against a queue-per-lane reference model.
module tb_ext2red_lane_buffer;

    localparam int W  = 30;
    localparam int NE = 8;
    localparam int D  = 8;
    localparam int AF = D - 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NE-1:0]   lane_wen = '0;
    logic [W*NE-1:0] lane_din = '0;
    logic [NE-1:0]   lane_full, lane_afull, valid;
    logic [W*NE-1:0] offset;
    logic            all_valid;
    logic            read = 1'b0;
    logic            flush = 1'b0;
`ifdef EXT2RED_ERR_EN
    logic            err_overflow, err_underflow;
`endif

    always #5 clk = ~clk;

    ext2red_lane_buffer #(
        .FIFO_WIDTH(W), .NUM_EXTEND(NE), .DEPTH(D), .AFULL_THRESH(AF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lane_wen(lane_wen), .lane_din(lane_din),
        .lane_full(lane_full), .lane_afull(lane_afull), .offset(offset),
        .valid(valid), .all_valid(all_valid), .read(read), .flush(flush)
`ifdef EXT2RED_ERR_EN
        , .err_overflow(err_overflow), .err_underflow(err_underflow)
`endif
    );

    typedef struct {
        logic [NE-1:0]   valid;
        logic [NE-1:0]   full;
        logic [NE-1:0]   afull;
        logic            allv;
        logic [W*NE-1:0] off;
        logic            eov;
        logic            eun;
    } exp_t;

    typedef logic [W-1:0] lane_q_t[$];

    exp_t    exp_q[$];
    lane_q_t mq[NE];
    bit      m_eov = 0, m_eun = 0;
    int      errors = 0, checks = 0;

    function automatic exp_t model_view();
        exp_t e;
        e.valid = '0; e.full = '0; e.afull = '0; e.off = '0;
        for (int i = 0; i < NE; i++) begin
            e.valid[i] = mq[i].size() > 0;
            e.full[i]  = mq[i].size() == D;
            e.afull[i] = mq[i].size() >= AF;
            if (mq[i].size() > 0) e.off[i*W +: W] = mq[i][0];
        end
        e.allv = &e.valid;
        e.eov  = m_eov;
        e.eun  = m_eun;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NE; i++) mq[i].delete();
        m_eov = 0;
        m_eun = 0;
    endtask

    task automatic model_step(input logic [NE-1:0] wen, input logic [W*NE-1:0] din,
                              input logic rd, input logic fl);
        bit allv;
        if (fl) begin
            model_clear();
            return;
        end
        allv = 1;
        for (int i = 0; i < NE; i++) if (mq[i].size() == 0) allv = 0;
        if (rd && !allv) m_eun = 1;
        for (int i = 0; i < NE; i++) begin
            if (rd && allv) void'(mq[i].pop_front());
            if (wen[i]) begin
                if (mq[i].size() < D) mq[i].push_back(din[i*W +: W]);
                else m_eov = 1;
            end
        end
    endtask

    task automatic cyc(input logic [NE-1:0] wen, input logic [W*NE-1:0] din,
                       input logic rd, input logic fl);
        @(posedge clk);
        #1;
        exp_q.push_back(model_view());
        lane_wen = wen;
        lane_din = din;
        read     = rd;
        flush    = fl;
        model_step(wen, din, rd, fl);
    endtask

    task automatic idle();
        cyc('0, '0, 1'b0, 1'b0);
    endtask

    // Drops rst_n between rising edges; the following negedge sample sees the result.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        lane_wen = '0; lane_din = '0; read = 1'b0; flush = 1'b0;
        model_clear();
        exp_q.push_back(model_view());
        @(posedge clk);
        #1;
        exp_q.push_back(model_view());
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [W*NE-1:0] act, input logic [W*NE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("valid",      (W*NE)'(valid),      (W*NE)'(e.valid));
            chk("all_valid",  (W*NE)'(all_valid),  (W*NE)'(e.allv));
            chk("lane_full",  (W*NE)'(lane_full),  (W*NE)'(e.full));
            chk("lane_afull", (W*NE)'(lane_afull), (W*NE)'(e.afull));
            chk("offset",     offset,              e.off);
`ifdef EXT2RED_ERR_EN
            chk("err_overflow",  (W*NE)'(err_overflow),  (W*NE)'(e.eov));
            chk("err_underflow", (W*NE)'(err_underflow), (W*NE)'(e.eun));
`endif
        end
    end

    function automatic logic [W*NE-1:0] fill_all(input int base);
        logic [W*NE-1:0] d;
        d = '0;
        for (int i = 0; i < NE; i++) d[i*W +: W] = W'(base + i);
        return d;
    endfunction

    function automatic logic [W*NE-1:0] rand_din();
        logic [W*NE-1:0] d;
        d = '0;
        for (int i = 0; i < NE; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [W*NE-1:0] d;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        idle();
        idle();

        // Single-lane write, then a read that must be ignored.
        d = '0;
        d[W-1:0] = W'(1);
        cyc(8'h01, d, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        idle();
        cyc('0, '0, 1'b0, 1'b1);
        idle();

        // All lanes written in one cycle, then one pop.
        cyc(8'hFF, fill_all(32'h100), 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        idle();

        // Fill lane 3 to full, overflow it, then write coincident with a pop.
        do_reset();
        for (int k = 0; k < D; k++) begin
            d = '0;
            d[3*W +: W] = W'(k);
            cyc(8'h08, d, 1'b0, 1'b0);
        end
        d = '0;
        d[3*W +: W] = W'(8);
        cyc(8'h08, d, 1'b0, 1'b0);
        cyc(8'hF7, fill_all(32'h200), 1'b0, 1'b0);
        d = '0;
        d[3*W +: W] = W'(9);
        cyc(8'h08, d, 1'b1, 1'b0);
        idle();

        // Flush with five entries per lane and flags set, racing a full write.
        cyc('0, '0, 1'b0, 1'b1);
        cyc('0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cyc(8'hFF, fill_all(32'h300 + 16 * k), 1'b0, 1'b0);
        cyc(8'hFF, fill_all(32'h3F0), 1'b0, 1'b1);
        idle();

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 3; k++) cyc(NE'($urandom), rand_din(), 1'b0, 1'b0);
        do_reset();
        d = '0;
        for (int i = 0; i < NE; i++) d[i*W +: W] = W'(32'h2A);
        cyc(8'hFF, d, 1'b0, 1'b0);
        idle();
        cyc('0, '0, 1'b1, 1'b0);
        idle();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic [NE-1:0] wen;
            wen = '0;
            for (int i = 0; i < NE; i++) wen[i] = ($urandom_range(0, 99) < 60);
            cyc(wen, rand_din(), ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 2));
        end
        idle();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
